// File: rtl/alu181_core.sv
// alu181_core: 8-bit registered ALU with a 74181-style function set.
//
// Ports:
//   CLK       rising-edge clock
//   RST       synchronous, active-high reset (F=0, CarryOut=1, Zero=1)
//   A, B      operands (WIDTH bits)
//   CarryIn   carry/borrow input for arithmetic ops; ignored in logic mode
//   Mode      1 = logic function, 0 = arithmetic operation
//   Selector  function code within the selected mode
//   F         registered result
//   CarryOut  registered carry/borrow flag, active-low (0 = carry/borrow)
//   Zero      registered zero flag, active-low (0 = F is all zeros)
//
// Timing: there is no handshake. Every cycle is accepted unconditionally
// (the implicit valid is always 1 and the implicit ready is always 1).
// The result of the inputs present at a rising edge appears on F/CarryOut/Zero
// right after that edge, so the latency is one cycle.
module alu181_core #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  input  logic             Mode,
  input  logic [3:0]       Selector,
  output logic [WIDTH-1:0] F,
  output logic             CarryOut,
  output logic             Zero
);

  localparam logic [3:0] SEL_DEC = 4'h0;
  localparam logic [3:0] SEL_DBL = 4'h3;
  localparam logic [3:0] SEL_ADD = 4'h6;
  localparam logic [3:0] SEL_SUB = 4'h9;
  localparam logic [3:0] SEL_EX  = 4'hC;
  localparam logic [3:0] SEL_INC = 4'hF;

  // Operands are widened by one bit so that bit WIDTH of the sum/difference
  // is the carry (add-type) or the borrow (subtract-type, wraps negative).
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   ncin_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] f_next;
  logic             carry_evt;   // active-high: a carry or borrow occurred
  logic             hold_carry;  // logic mode leaves CarryOut untouched

  assign a_ext    = {1'b0, A};
  assign b_ext    = {1'b0, B};
  assign cin_ext  = {{WIDTH{1'b0}}, CarryIn};
  assign ncin_ext = {{WIDTH{1'b0}}, ~CarryIn};

  always_comb begin
    sum        = a_ext;
    f_next     = A;
    carry_evt  = 1'b0;
    hold_carry = 1'b0;
    if (Mode) begin
      hold_carry = 1'b1;
      case (Selector)
        4'h0: f_next = A;
        4'h1: f_next = A | B;
        4'h2: f_next = A | ~B;
        4'h3: f_next = {WIDTH{1'b1}};
        4'h4: f_next = A & B;
        4'h5: f_next = B;
        4'h6: f_next = ~(A ^ B);
        4'h7: f_next = ~A | B;
        4'h8: f_next = A & ~B;
        4'h9: f_next = A ^ B;
        4'hA: f_next = ~B;
        4'hB: f_next = ~(A & B);
        4'hC: f_next = {WIDTH{1'b0}};
        4'hD: f_next = ~A & B;
        4'hE: f_next = ~(A | B);
        default: f_next = ~A;
      endcase
    end else begin
      case (Selector)
        SEL_DEC: begin
          sum       = a_ext - cin_ext;
          f_next    = sum[WIDTH-1:0];
          carry_evt = sum[WIDTH];
        end
        SEL_DBL: begin
          sum       = a_ext + a_ext + cin_ext;
          f_next    = sum[WIDTH-1:0];
          carry_evt = sum[WIDTH];
        end
        SEL_ADD: begin
          sum       = a_ext + b_ext + cin_ext;
          f_next    = sum[WIDTH-1:0];
          carry_evt = sum[WIDTH];
        end
        SEL_SUB: begin
          sum       = a_ext - b_ext - cin_ext;
          f_next    = sum[WIDTH-1:0];
          carry_evt = sum[WIDTH];
        end
        SEL_EX: begin
          f_next = {WIDTH{CarryIn}};
        end
        SEL_INC: begin
          // CarryIn is inverted: CarryIn=0 means increment by one.
          sum       = a_ext + ncin_ext;
          f_next    = sum[WIDTH-1:0];
          carry_evt = sum[WIDTH];
        end
        default: f_next = A;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      F        <= '0;
      CarryOut <= 1'b1;
      Zero     <= 1'b1;
    end else begin
      F <= f_next;
      if (!hold_carry) begin
        CarryOut <= ~carry_evt;
      end
      Zero <= |f_next;
    end
  end

endmodule

// File: tb/tb_alu181_core.sv
// tb_alu181_core: directed test-plan steps followed by random operations,
// all checked against an integer-arithmetic reference model.
module tb_alu181_core;

  localparam int W = 8;

  // ---------------- clock / reset block ----------------
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CarryIn = 1'b0;
  logic         Mode = 1'b0;
  logic [3:0]   Selector = '0;
  logic [W-1:0] F;
  logic         CarryOut;
  logic         Zero;

  always #5 CLK = ~CLK;

  alu181_core #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .A        (A),
    .B        (B),
    .CarryIn  (CarryIn),
    .Mode     (Mode),
    .Selector (Selector),
    .F        (F),
    .CarryOut (CarryOut),
    .Zero     (Zero)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [W+1:0] exp_q[$];   // {f, carryout, zero}
  logic         mdl_c = 1'b1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic logic [W+1:0] model(input logic rst, input logic mode,
                                         input logic [3:0] sel, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin,
                                         input logic prev_c);
    int mask, ai, bi, ci, r;
    logic [W-1:0] f;
    logic c;
    mask = (1 << W) - 1;
    ai = int'(a);
    bi = int'(b);
    ci = cin ? 1 : 0;
    c  = prev_c;
    if (rst) return {{W{1'b0}}, 1'b1, 1'b1};
    if (mode) begin
      case (sel)
        4'h0: f = a;
        4'h1: f = a | b;
        4'h2: f = a | ~b;
        4'h3: f = '1;
        4'h4: f = a & b;
        4'h5: f = b;
        4'h6: f = ~(a ^ b);
        4'h7: f = ~a | b;
        4'h8: f = a & ~b;
        4'h9: f = a ^ b;
        4'hA: f = ~b;
        4'hB: f = ~(a & b);
        4'hC: f = '0;
        4'hD: f = ~a & b;
        4'hE: f = ~(a | b);
        default: f = ~a;
      endcase
    end else begin
      case (sel)
        4'h0: begin r = ai - ci;          c = !(r < 0); end
        4'h3: begin r = 2 * ai + ci;      c = !(r > mask); end
        4'h6: begin r = ai + bi + ci;     c = !(r > mask); end
        4'h9: begin r = ai - bi - ci;     c = !(r < 0); end
        4'hC: begin r = ci ? mask : 0;    c = 1'b1; end
        4'hF: begin r = ai + (1 - ci);    c = !(r > mask); end
        default: begin r = ai;            c = 1'b1; end
      endcase
      f = W'(r & mask);
    end
    return {f, c, (f != '0)};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic rst, input logic mode,
                      input logic [3:0] sel, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic cin);
    logic [W+1:0] e;
    RST = rst; Mode = mode; Selector = sel; A = a; B = b; CarryIn = cin;
    e = model(rst, mode, sel, a, b, cin, mdl_c);
    mdl_c = e[1];
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check({tag, ".f"}, F, e[W+1:2]);
    check({tag, ".c"}, W'(CarryOut), W'(e[1]));
    check({tag, ".z"}, W'(Zero), W'(e[0]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, then a first add.
    step("rst", 1'b1, 1'b0, 4'h6, 8'hAA, 8'h55, 1'b1);
    check("rst_f", F, 8'h00);
    check("rst_c", W'(CarryOut), 8'h01);
    check("rst_z", W'(Zero), 8'h01);
    step("add1", 1'b0, 1'b0, 4'h6, 8'h01, 8'h01, 1'b0);
    check("add1_f", F, 8'h02);

    // DEC then INC.
    step("dec", 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
    check("dec_f", F, 8'hFF);
    check("dec_c", W'(CarryOut), 8'h00);
    step("inc", 1'b0, 1'b0, 4'hF, 8'hEC, 8'h00, 1'b0);
    check("inc_f", F, 8'hED);
    check("inc_c", W'(CarryOut), 8'h01);

    // SUB without and with borrow.
    step("sub1", 1'b0, 1'b0, 4'h9, 8'h10, 8'h01, 1'b0);
    check("sub1_f", F, 8'h0F);
    step("sub2", 1'b0, 1'b0, 4'h9, 8'h01, 8'h03, 1'b0);
    check("sub2_f", F, 8'hFE);
    check("sub2_c", W'(CarryOut), 8'h00);

    // ADD with wrap to zero; leaves CarryOut=0 for the logic ops.
    step("addc", 1'b0, 1'b0, 4'h6, 8'hF1, 8'h0F, 1'b0);
    check("addc_f", F, 8'h00);
    check("addc_c", W'(CarryOut), 8'h00);
    check("addc_z", W'(Zero), 8'h00);

    // Logic functions: CarryOut must hold at 0 even with CarryIn toggling.
    step("and",  1'b0, 1'b1, 4'h4, 8'hF1, 8'h0F, 1'b1);
    check("and_f", F, 8'h01);
    step("xor",  1'b0, 1'b1, 4'h9, 8'h21, 8'h0F, 1'b0);
    check("xor_f", F, 8'h2E);
    step("or",   1'b0, 1'b1, 4'h1, 8'h04, 8'hF4, 1'b1);
    check("or_f", F, 8'hF4);
    step("zero", 1'b0, 1'b1, 4'hC, 8'h5A, 8'hA5, 1'b0);
    check("zero_z", W'(Zero), 8'h00);
    step("ones", 1'b0, 1'b1, 4'h3, 8'h00, 8'h00, 1'b1);
    check("ones_f", F, 8'hFF);
    step("nop",  1'b0, 1'b1, 4'h0, 8'h11, 8'h22, 1'b0);
    check("nop_f", F, 8'h11);
    check("nop_c", W'(CarryOut), 8'h00);

    // DBL, EX, then reset in the middle of back-to-back ops.
    step("dbl", 1'b0, 1'b0, 4'h3, 8'h80, 8'h00, 1'b0);
    check("dbl_f", F, 8'h00);
    check("dbl_c", W'(CarryOut), 8'h00);
    step("ex",  1'b0, 1'b0, 4'hC, 8'h12, 8'h34, 1'b1);
    check("ex_f", F, 8'hFF);
    step("pre", 1'b0, 1'b0, 4'h6, 8'hFF, 8'h01, 1'b0);
    step("mid_rst", 1'b1, 1'b0, 4'h6, 8'hFF, 8'h01, 1'b1);
    check("mid_rst_f", F, 8'h00);
    check("mid_rst_c", W'(CarryOut), 8'h01);
    step("post", 1'b0, 1'b0, 4'h9, 8'h00, 8'h00, 1'b1);

    // Random operations, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           W'($urandom),
           W'($urandom),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu181_core.md
Name: alu181_core

Overview:
- 8-bit registered arithmetic/logic unit with a 74181-style function set.
- A 1-bit Mode selects between 16 logic functions and a set of arithmetic operations; a 4-bit Selector picks the function within the mode.
- Sits in the CPU datapath between the register file/operand muxes and the accumulator/flag register.
- Result and two active-low flags (Carry, Zero) are registered on the clock.

Parameters:
- WIDTH, 8, operand/result width; all arithmetic rules below are stated for WIDTH=8 and scale to WIDTH.

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  synchronous reset, active-high
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- CarryIn  input  1  carry/borrow input; per-operation meaning given below
- Mode  input  1  1 = logic function, 0 = arithmetic operation
- Selector  input  4  function code
- F  output  WIDTH  registered result
- CarryOut  output  1  registered carry/borrow flag, active-low (0 = carry or borrow occurred)
- Zero  output  1  registered zero flag, active-low (0 = F is all zeros)

Behaviour:
- Single clock, CLK. Reset RST is synchronous and active-high.
- On a CLK rising edge with RST=1: F=0, CarryOut=1, Zero=1 (both flags inactive). RST has priority over any operation in progress.
- Otherwise, every rising edge registers the result of the current inputs. Latency is 1 cycle; there is no handshake and a new operation can start every cycle.
- Inputs are combinationally evaluated; only F, CarryOut and Zero are state.
- Logic mode (Mode=1), per Selector:
  - 0: F=A
  - 1: A|B
  - 2: A|~B
  - 3: all ones
  - 4: A&B
  - 5: B
  - 6: ~(A^B)
  - 7: ~A|B
  - 8: A&~B
  - 9: A^B
  - A: ~B
  - B: ~(A&B)
  - C: all zeros
  - D: ~A&B
  - E: ~(A|B)
  - F: ~A
  - CarryIn is ignored. CarryOut holds its previous value. Zero is updated.
- Arithmetic mode (Mode=0): compute in WIDTH+1 bits; F = low WIDTH bits. Per Selector:
  - 0 (DEC): F = A − CarryIn, so CarryIn=1 gives A−1. Borrow occurs when A < CarryIn.
  - 3 (DBL): F = A + A + CarryIn. Carry = bit WIDTH of the sum.
  - 6 (ADD): F = A + B + CarryIn. Carry = bit WIDTH of the sum.
  - 9 (SUB): F = A − B − CarryIn. Borrow occurs when A < B + CarryIn.
  - C (EX, carry extension): F = all CarryIn, i.e. 0xFF if CarryIn=1, else 0x00. No carry.
  - F (INC): F = A + ~CarryIn, so CarryIn=0 gives A+1. Carry = bit WIDTH of the sum.
  - All other codes: F = A. No carry.
  - CarryOut = 0 when a carry (add-type ops) or borrow (subtract-type ops) occurred, else 1.
- Zero = 0 exactly when the newly registered F is all zeros, in both modes.
- Wrap-around is modulo 2^WIDTH. Example: 0xFF+1 gives F=0x00, CarryOut=0, Zero=0.
- X/undefined inputs are not required to be handled. Selector and Mode are fully decoded with no illegal codes.

Test Plan:
- Reset: drive RST=1 for one edge with any inputs -> F=0x00, CarryOut=1, Zero=1. Then release RST and apply ADD 0x01+0x01 -> next edge F=0x02.
- DEC then INC:
  - Mode=0, Sel=0, A=0x00, CarryIn=1 -> F=0xFF, CarryOut=0, Zero=1.
  - Next cycle Sel=F, A=0xEC, CarryIn=0 -> F=0xED, CarryOut=1, Zero=1.
- ADD with carry: Mode=0, Sel=6, A=0xF1, B=0x0F, CarryIn=0 -> F=0x00, CarryOut=0, Zero=0.
- SUB:
  - A=0x10, B=0x01, CarryIn=0 -> F=0x0F, CarryOut=1.
  - Then A=0x01, B=0x03 -> F=0xFE, CarryOut=0 (borrow), Zero=1.
- Logic functions:
  - Precondition: CarryOut=0 from a prior ADD.
  - AND 0xF1&0x0F -> F=0x01.
  - XOR 0x21^0x0F -> F=0x2E.
  - OR 0x04|0xF4 -> F=0xF4.
  - ALLZERO -> F=0x00, Zero=0.
  - ALLONE -> F=0xFF, Zero=1.
  - NOP A=0x11 -> F=0x11.
  - CarryOut stays 0 throughout.
- DBL/EX plus reset mid-stream:
  - DBL A=0x80, CarryIn=0 -> F=0x00, CarryOut=0, Zero=0.
  - EX with CarryIn=1 -> F=0xFF.
  - Assert RST during a stream of back-to-back ops -> flags and F return to reset values on that edge.
